// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Raster timing and test-pattern source feeding the text-overlay stage.
//   Produces an active/blank raster from parameterised counts and fills
//   active pixels with one of four patterns. Start/stop and pattern changes
//   only take effect on frame boundaries; reset acts immediately.
// Ports:
//   i_clk          pixel clock
//   i_rst          synchronous reset, active-high
//   i_enable       run request, sampled at idle or at the frame boundary
//   i_pattern_sel  0 black, 1 white, 2 horizontal ramp, 3 checkerboard
//   o_data         pixel value, 0 outside active pixels
//   o_vactive      high for the whole of an active line (incl. h-blank)
//   o_hactive      high on active pixels only
//   o_frame_start  one-cycle pulse with pixel (0,0)
module video_pattern_gen #(
   parameter int DATA_WIDTH   = 12,
   parameter int H_ACTIVE     = 640,
   parameter int H_BLANK      = 160,
   parameter int V_ACTIVE     = 480,
   parameter int V_BLANK      = 45,
   parameter int CHECKER_LOG2 = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic [1:0]            i_pattern_sel,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_vactive,
   output logic                  o_hactive,
   output logic                  o_frame_start
);

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return (r < 1) ? 1 : r;
   endfunction

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int HW      = clog2(H_TOTAL);
   localparam int VW      = clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);

   if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 || V_BLANK < 1 ||
       CHECKER_LOG2 >= HW) begin : g_bad_param
      $fatal(1, "video_pattern_gen: illegal parameter set");
   end

   logic                  running_q, running_d;
   logic [HW-1:0]         h_q, h_d;
   logic [VW-1:0]         v_q, v_d;
   logic [1:0]            pat_q, pat_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  vact_d, hact_d, fs_d;
   logic [1:0]            pat_cur;
   logic                  v_chk;

   // A short frame may have fewer v bits than the checker index; treat the
   // missing bit as 0 so squares still alternate horizontally.
   if (CHECKER_LOG2 < VW) begin : g_vchk
      assign v_chk = v_q[CHECKER_LOG2];
   end else begin : g_vchk0
      assign v_chk = 1'b0;
   end

   always_comb begin
      running_d = running_q;
      h_d       = h_q;
      v_d       = v_q;
      pat_d     = pat_q;
      data_d    = '0;
      vact_d    = 1'b0;
      hact_d    = 1'b0;
      fs_d      = 1'b0;
      // Starting from idle uses the live select for pixel (0,0).
      pat_cur   = running_q ? pat_q : i_pattern_sel;
      if (running_q || i_enable) begin
         vact_d = (v_q < V_ACT_C);
         hact_d = vact_d && (h_q < H_ACT_C);
         fs_d   = (h_q == '0) && (v_q == '0);
         if (hact_d) begin
            case (pat_cur)
               2'd0:    data_d = '0;
               2'd1:    data_d = '1;
               2'd2:    data_d = DATA_WIDTH'(h_q);
               default: data_d = {DATA_WIDTH{h_q[CHECKER_LOG2] ^ v_chk}};
            endcase
         end
         if (!running_q) begin
            running_d = 1'b1;
            pat_d     = i_pattern_sel;
         end
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               // Frame boundary: the only point where enable/select are heeded.
               v_d       = '0;
               running_d = i_enable;
               pat_d     = i_pattern_sel;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         running_q     <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         pat_q         <= '0;
         o_data        <= '0;
         o_vactive     <= 1'b0;
         o_hactive     <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         running_q     <= running_d;
         h_q           <= h_d;
         v_q           <= v_d;
         pat_q         <= pat_d;
         o_data        <= data_d;
         o_vactive     <= vact_d;
         o_hactive     <= hact_d;
         o_frame_start <= fs_d;
      end
   end

endmodule
